vram_addr_seq: RTL and testbench
================================

VRAM_ADDR_SEQ -- requirements
Module: vram_addr_seq

Interface
REQ-001 SHALL have parameter NCH, default 4, range 2..8: number of address channels; channel 0 is the CPU channel.
REQ-002 SHALL have parameter AW, default 13: width of each channel address and of RA.
REQ-003 SHALL have derived localparam SW = max(1, clog2(NCH)): width of slot and channel indices.
REQ-004 SHALL have port M24, input, 1: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port RESn, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port CE, input, 1: slot-advance enable, one pulse per access slot.
REQ-007 SHALL have port MODE, input, 1: 0 = fixed rotation, 1 = CPU-priority steal.
REQ-008 SHALL have port ADDR_IN, input, NCH*AW: channel n address in bits [n*AW +: AW].
REQ-009 SHALL have port CPU_REQ, input, 1: CPU access request, level, sampled per clock.
REQ-010 SHALL have port CPU_ACK, output, 1: one-clock pulse when the CPU address has been driven.
REQ-011 SHALL have port RA, output, AW: registered selected VRAM address.
REQ-012 SHALL have port RA_CH, output, SW: channel index currently driving RA.
REQ-013 SHALL have port RA_VLD, output, 1: RA holds a serviced address this slot.
REQ-014 SHALL have port SLOT, output, SW: current slot counter value.

Function
REQ-015 SLOT SHALL advance by 1 on each clock with CE=1, wrapping NCH-1 -> 0; it SHALL hold when CE=0.
REQ-016 A pending flag SHALL be set on a CPU_REQ 0->1 edge, detected against a registered copy of CPU_REQ.
REQ-017 The pending flag SHALL clear on the clock on which the CPU is serviced.
REQ-018 CPU_REQ held high after service SHALL NOT re-set the pending flag; a new request requires CPU_REQ low for at least 1 clock.
REQ-019 On a CE clock, the selection SHALL use the SLOT value before increment and the pending value including a same-cycle edge; an edge coinciding with its slot is serviced in that slot.
REQ-020 MODE=0, slot s != 0, on a CE clock: RA <= ADDR_IN[s], RA_CH <= s, RA_VLD <= 1.
REQ-021 MODE=0, slot 0 with pending on a CE clock: RA <= ADDR_IN[0], RA_CH <= 0, RA_VLD <= 1, pending cleared.
REQ-022 MODE=0, slot 0 with no pending on a CE clock: RA and RA_CH hold, RA_VLD <= 0.
REQ-023 MODE=1: on any CE clock with pending, the CPU SHALL be serviced regardless of slot; the displaced channel is skipped, not deferred, and SLOT still advances.
REQ-024 MODE=1 with no pending SHALL behave as MODE=0.
REQ-025 CPU_ACK SHALL be 1 for exactly the one clock following the CE clock that loaded the CPU address, and 0 otherwise.
REQ-026 Latency SHALL be: ADDR_IN sampled on the CE edge, RA/RA_CH/RA_VLD valid after that edge, stable until the next CE edge.
REQ-027 On non-CE clocks, RA, RA_CH and RA_VLD SHALL hold; the CE=0 state does not clear RA_VLD.
REQ-028 A MODE change SHALL take effect on the next CE clock, with no glitch in SLOT.
REQ-029 RA SHALL be a plain AW-bit copy with no arithmetic; channel indices >= NCH SHALL never be produced.

Reset
REQ-030 While RESn=0, regardless of M24: SLOT=0, RA=0, RA_CH=0, RA_VLD=0, CPU_ACK=0, pending=0, CPU_REQ history=0.
REQ-031 Reset asserted mid-request SHALL drop the pending request with no ACK issued.
REQ-032 After RESn deassertion, a CPU_REQ already high SHALL count as a new edge on the first clock.
REQ-033 The first CE after reset SHALL service slot 0.

Verification (NCH=4, AW=13)
REQ-034 MODE=0, CE every clock, ADDR_IN = {0x1333, 0x0222, 0x0111, 0x0AAA}, no CPU_REQ -> RA = 0x0111, 0x0222, 0x1333, then a hold with RA_VLD=0 at slot 0, repeating.
REQ-035 MODE=0, CPU_REQ rises on the CE clock of slot 0 -> RA = 0x0AAA, RA_CH = 0, RA_VLD = 1, CPU_ACK pulses 1 clock later; holding CPU_REQ high yields no second ACK on the next slot-0 pass.
REQ-036 MODE=1, CPU_REQ rises at slot 2 -> slot 2 drives 0x0AAA with RA_CH = 0, ACK pulses, and slot 3 next drives 0x1333; channel 2 is skipped.
REQ-037 CE asserted 1 clock in 3 -> SLOT and RA change only on CE clocks, and CPU_ACK remains a single-clock pulse.
REQ-038 RESn pulsed low asynchronously, between edges, while a request is pending -> all outputs 0 immediately; no ACK ever appears for that request.
REQ-039 MODE toggled 0->1 with a request pending at slot 1 -> serviced at slot 1 on the next CE, with no lost or duplicate ACK.

Source files
------------

// File: rtl/vram_addr_seq.sv
// VRAM address sequencer: rotates NCH address channels through access slots
// and lets the CPU channel (0) claim its own slot or, in steal mode, any slot.
module vram_addr_seq #(
  parameter  int NCH = 4,
  parameter  int AW  = 13,
  localparam int SW  = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic              M24,
  input  logic              RESn,
  input  logic              CE,
  input  logic              MODE,
  input  logic [NCH*AW-1:0] ADDR_IN,
  input  logic              CPU_REQ,
  output logic              CPU_ACK,
  output logic [AW-1:0]     RA,
  output logic [SW-1:0]     RA_CH,
  output logic              RA_VLD,
  output logic [SW-1:0]     SLOT
);

  logic [AW-1:0] ch_addr [NCH];
  logic          req_p0;
  logic          pend_p0;
  logic [SW-1:0] slot_p0;
  logic          req_rise;
  logic          pend_eff;
  logic          cpu_take;
  logic [SW-1:0] slot_nxt;

  for (genvar n = 0; n < NCH; n++) begin : g_unpack
    assign ch_addr[n] = ADDR_IN[n*AW +: AW];
  end

  // A rise seen this clock counts as already pending, so a request that lands
  // on its own slot is serviced without waiting a full rotation.
  always_comb begin
    req_rise = CPU_REQ & ~req_p0;
    pend_eff = pend_p0 | req_rise;
    cpu_take = CE & pend_eff & (MODE | (slot_p0 == '0));
    slot_nxt = (slot_p0 == SW'(NCH - 1)) ? '0 : slot_p0 + SW'(1);
  end

  // Stage p0: request history, pending flag, slot counter and ACK
  always_ff @(posedge M24 or negedge RESn) begin
    if (!RESn) begin
      req_p0  <= 1'b0;
      pend_p0 <= 1'b0;
      slot_p0 <= '0;
      CPU_ACK <= 1'b0;
    end else begin
      req_p0  <= CPU_REQ;
      pend_p0 <= pend_eff & ~cpu_take;
      CPU_ACK <= cpu_take;
      if (CE) begin
        slot_p0 <= slot_nxt;
      end
    end
  end

  // Stage p0 output: selected address; an idle CPU slot keeps the last
  // address on RA but flags it as not serviced.
  always_ff @(posedge M24 or negedge RESn) begin
    if (!RESn) begin
      RA     <= '0;
      RA_CH  <= '0;
      RA_VLD <= 1'b0;
    end else if (CE) begin
      if (cpu_take) begin
        RA     <= ch_addr[0];
        RA_CH  <= '0;
        RA_VLD <= 1'b1;
      end else if (slot_p0 != '0) begin
        RA     <= ch_addr[slot_p0];
        RA_CH  <= slot_p0;
        RA_VLD <= 1'b1;
      end else begin
        RA_VLD <= 1'b0;
      end
    end
  end

  assign SLOT = slot_p0;

endmodule

// File: tb/tb_vram_addr_seq.sv
// Scoreboard bench for vram_addr_seq: inputs change on the falling edge, the
// behavioural model's expectation is queued, and a monitor checks after each rise.
module tb_vram_addr_seq;
  localparam int NCH = 4;
  localparam int AW  = 13;
  localparam int SW  = 2;

  logic              M24 = 1'b0;
  logic              RESn;
  logic              CE;
  logic              MODE;
  logic              CPU_REQ;
  logic [NCH*AW-1:0] ADDR_IN;
  logic              CPU_ACK;
  logic [AW-1:0]     RA;
  logic [SW-1:0]     RA_CH;
  logic              RA_VLD;
  logic [SW-1:0]     SLOT;
  logic [AW-1:0]     addr [NCH];

  vram_addr_seq #(.NCH(NCH), .AW(AW)) dut (
    .M24(M24), .RESn(RESn), .CE(CE), .MODE(MODE), .ADDR_IN(ADDR_IN),
    .CPU_REQ(CPU_REQ), .CPU_ACK(CPU_ACK), .RA(RA), .RA_CH(RA_CH),
    .RA_VLD(RA_VLD), .SLOT(SLOT)
  );

  always #5 M24 = ~M24;

  always_comb begin
    ADDR_IN = '0;
    for (int i = 0; i < NCH; i++) ADDR_IN[i*AW +: AW] = addr[i];
  end

  typedef struct packed {
    logic [AW-1:0] ra;
    logic [SW-1:0] ch;
    logic          vld;
    logic          ack;
    logic [SW-1:0] slot;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   checks = 0;
  int   errors = 0;

  // Reference model state: slot as an integer, CPU request as a pending bit
  int            m_slot;
  bit            m_pend, m_prev, m_vld, m_ack;
  logic [AW-1:0] m_ra;
  int            m_ch;

  task automatic model_step(input bit rn, input bit ce, input bit md, input bit rq);
    bit   rise, pend;
    int   s;
    exp_t ne;
    if (!rn) begin
      m_slot = 0; m_pend = 0; m_prev = 0; m_ra = '0; m_ch = 0; m_vld = 0; m_ack = 0;
    end else begin
      rise   = rq && !m_prev;
      m_prev = rq;
      pend   = m_pend || rise;
      m_ack  = 0;
      if (ce) begin
        s = m_slot;
        if (pend && (md || s == 0)) begin
          m_ra = addr[0]; m_ch = 0; m_vld = 1; m_ack = 1; pend = 0;
        end else if (s != 0) begin
          m_ra = addr[s]; m_ch = s; m_vld = 1;
        end else begin
          m_vld = 0;
        end
        m_slot = (m_slot + 1) % NCH;
      end
      m_pend = pend;
    end
    ne.ra = m_ra; ne.ch = SW'(m_ch); ne.vld = m_vld; ne.ack = m_ack; ne.slot = SW'(m_slot);
    sb.push_back(ne);
  endtask

  task automatic chk_zero(input string name);
    checks++;
    if (RA !== '0 || RA_CH !== '0 || RA_VLD !== 1'b0 || CPU_ACK !== 1'b0 || SLOT !== '0) begin
      errors++;
      $display("FAIL %s t=%0t ra=%h ch=%0d vld=%b ack=%b slot=%0d, all required 0",
               name, $time, RA, RA_CH, RA_VLD, CPU_ACK, SLOT);
    end
  endtask

  task automatic step(input bit rn, input bit ce, input bit md, input bit rq,
                      input bit rnd_addr = 1'b0);
    @(negedge M24);
    if (rnd_addr) for (int i = 0; i < NCH; i++) addr[i] = AW'($urandom);
    RESn = rn; CE = ce; MODE = md; CPU_REQ = rq;
    if (!rn) begin
      #1;
      chk_zero("async_reset");
    end
    model_step(rn, ce, md, rq);
  endtask

  task automatic run_to_slot(input int target, input bit md);
    while (m_slot != target) step(1'b1, 1'b1, md, 1'b0);
  endtask

  initial begin
    forever begin
      @(posedge M24);
      #2;
      if (sb.size() > 0) begin
        got = sb.pop_front();
        checks++;
        if (RA !== got.ra || RA_CH !== got.ch || RA_VLD !== got.vld ||
            CPU_ACK !== got.ack || SLOT !== got.slot) begin
          errors++;
          $display("FAIL sb t=%0t ra=%h want %h ch=%0d want %0d vld=%b want %b ack=%b want %b slot=%0d want %0d",
                   $time, RA, got.ra, RA_CH, got.ch, RA_VLD, got.vld, CPU_ACK, got.ack, SLOT, got.slot);
        end
      end
    end
  end

  initial begin
    bit rn, ce, md, rq;
    RESn = 1'b0; CE = 1'b0; MODE = 1'b0; CPU_REQ = 1'b0;
    addr[0] = 13'h0AAA; addr[1] = 13'h0111; addr[2] = 13'h0222; addr[3] = 13'h1333;
    m_slot = 0; m_pend = 0; m_prev = 0; m_ra = '0; m_ch = 0; m_vld = 0; m_ack = 0;
    @(posedge M24);
    #1;
    chk_zero("reset_state");
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Fixed rotation, no CPU traffic
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, 1'b0);

    // CPU request rising on the slot-0 clock, then held high
    run_to_slot(0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);

    // Steal mode: request rising at slot 2 displaces channel 2
    run_to_slot(2, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);

    // Slot enable one clock in three
    for (int i = 0; i < 24; i++) step(1'b1, (i % 3) == 0, 1'b0, (i >= 5 && i < 12));

    // Reset while a request is pending
    run_to_slot(1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0);

    // Request already high when reset releases counts as a new edge
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);

    // Mode switched to steal with a request pending at slot 1
    run_to_slot(1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);

    // Randomized traffic
    md = 1'b0; rq = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      rn = ($urandom_range(0, 149) != 0);
      ce = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) md = ~md;
      if ($urandom_range(0, 3) == 0) rq = ~rq;
      step(rn, ce, md, rq, ($urandom_range(0, 3) == 0));
    end

    @(posedge M24);
    #4;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
